// File: rtl/el2_dec_ib_fifo.sv
// Decode instruction buffer: a DEPTH-entry fetch FIFO with an optional empty-buffer
// bypass, plus a one-entry debug command slot that takes priority over fetch.
module el2_dec_ib_fifo #(
    parameter int DEPTH    = 4,
    parameter int SB_WIDTH = 64,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     ifu_i0_valid,
    output logic                     ifu_ib_ready,
    input  logic [31:0]              ifu_i0_instr,
    input  logic [31:1]              ifu_i0_pc,
    input  logic                     ifu_i0_pc4,
    input  logic                     ifu_i0_icaf,
    input  logic                     ifu_i0_icaf_second,
    input  logic                     ifu_i0_dbecc,
    input  logic [1:0]               ifu_i0_icaf_type,
    input  logic [SB_WIDTH-1:0]      ifu_i0_sb,

    input  logic                     dec_i0_decode_d,
    input  logic                     exu_flush_final,

    input  logic                     dbg_cmd_valid,
    input  logic                     dbg_cmd_write,
    input  logic [1:0]               dbg_cmd_type,
    input  logic [31:0]              dbg_cmd_addr,
    output logic                     dbg_cmd_ready,

    output logic                     dec_ib0_valid_d,
    output logic                     dec_debug_valid_d,
    output logic [31:0]              dec_i0_instr_d,
    output logic [31:1]              dec_i0_pc_d,
    output logic                     dec_i0_pc4_d,
    output logic                     dec_i0_icaf_d,
    output logic                     dec_i0_icaf_second_d,
    output logic                     dec_i0_dbecc_d,
    output logic [1:0]               dec_i0_icaf_type_d,
    output logic [SB_WIDTH-1:0]      dec_i0_sb_d,
    output logic                     dec_debug_wdata_rs1_d,
    output logic                     dec_debug_fence_d,
    output logic [$clog2(DEPTH):0]   dec_ib_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        DBG_GPR = 2'd0,
        DBG_CSR = 2'd1,
        DBG_MEM = 2'd2
    } dbg_type_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [31:1]         pc;
        logic                pc4;
        logic                icaf;
        logic                icaf_second;
        logic                dbecc;
        logic [1:0]          icaf_type;
        logic [SB_WIDTH-1:0] sb;
    } ib_entry_t;

    ib_entry_t          storage_q [DEPTH];
    ib_entry_t          in_entry;
    ib_entry_t          head_entry;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dbg_pending_q, dbg_pending_d;
    logic [31:0]        dbg_instr_q, dbg_instr_d;
    logic               dbg_wr_q, dbg_wr_d;
    logic               dbg_fence_q, dbg_fence_d;

    logic               empty, full;
    logic               dbg_acc, enq, byp, deq, wr_en;
    logic [31:0]        dbg_enc;
    logic               unused_addr;

    assign unused_addr = ^dbg_cmd_addr[31:12];

    assign in_entry = '{
        instr:       ifu_i0_instr,
        pc:          ifu_i0_pc,
        pc4:         ifu_i0_pc4,
        icaf:        ifu_i0_icaf,
        icaf_second: ifu_i0_icaf_second,
        dbecc:       ifu_i0_dbecc,
        icaf_type:   ifu_i0_icaf_type,
        sb:          ifu_i0_sb
    };

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign dbg_acc = dbg_cmd_valid & (dbg_cmd_type != DBG_MEM) & ~dbg_pending_q & empty;

    // Ready deliberately ignores a same-cycle decode: no decode-to-ready timing path.
    assign ifu_ib_ready  = ~full & ~dbg_pending_q & ~dbg_acc & ~exu_flush_final;
    assign dbg_cmd_ready = dbg_acc;

    assign enq   = ifu_i0_valid & ifu_ib_ready;
    assign byp   = (BYPASS != 0) & empty & enq;
    assign wr_en = enq & ~(byp & dec_i0_decode_d);
    assign deq   = dec_i0_decode_d & ~empty & ~dbg_pending_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        dbg_enc = 32'h0000_6033;
        if (dbg_cmd_type == DBG_CSR) begin
            dbg_enc = (dbg_cmd_write ? 32'h0000_1073 : 32'h0000_2073)
                    | {dbg_cmd_addr[11:0], 20'b0};
        end else if (dbg_cmd_write) begin
            dbg_enc = 32'h0000_6033 | {20'b0, dbg_cmd_addr[4:0], 7'b0};
        end else begin
            dbg_enc = 32'h0000_6033 | {12'b0, dbg_cmd_addr[4:0], 15'b0};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (exu_flush_final) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);
        end
    end

    always_comb begin
        dbg_pending_d = dbg_pending_q;
        dbg_instr_d   = dbg_instr_q;
        dbg_wr_d      = dbg_wr_q;
        dbg_fence_d   = dbg_fence_q;
        if (dbg_acc) begin
            dbg_pending_d = 1'b1;
            dbg_instr_d   = dbg_enc;
            dbg_wr_d      = dbg_cmd_write;
            dbg_fence_d   = (dbg_cmd_type == DBG_CSR) & dbg_cmd_write
                          & (dbg_cmd_addr[11:0] == 12'h7C4);
        end else if (dbg_pending_q & dec_i0_decode_d) begin
            dbg_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dbg_pending_q <= 1'b0;
            dbg_instr_q   <= '0;
            dbg_wr_q      <= 1'b0;
            dbg_fence_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            dbg_pending_q <= dbg_pending_d;
            dbg_instr_q   <= dbg_instr_d;
            dbg_wr_q      <= dbg_wr_d;
            dbg_fence_q   <= dbg_fence_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) storage_q[wr_ptr_q] <= in_entry;
    end

    always_comb begin
        head_entry = '0;
        if (dbg_pending_q) begin
            head_entry.instr = dbg_instr_q;
        end else if (!empty) begin
            head_entry = storage_q[rd_ptr_q];
        end else if (byp) begin
            head_entry = in_entry;
        end
    end

    assign dec_ib0_valid_d       = dbg_pending_q | ~empty | byp;
    assign dec_debug_valid_d     = dbg_pending_q;
    assign dec_i0_instr_d        = head_entry.instr;
    assign dec_i0_pc_d           = head_entry.pc;
    assign dec_i0_pc4_d          = head_entry.pc4;
    assign dec_i0_icaf_d         = head_entry.icaf;
    assign dec_i0_icaf_second_d  = head_entry.icaf_second;
    assign dec_i0_dbecc_d        = head_entry.dbecc;
    assign dec_i0_icaf_type_d    = head_entry.icaf_type;
    assign dec_i0_sb_d           = head_entry.sb;
    assign dec_debug_wdata_rs1_d = dbg_pending_q & dbg_wr_q;
    assign dec_debug_fence_d     = dbg_pending_q & dbg_fence_q;
    assign dec_ib_count          = count_q;

endmodule

// File: tb/tb_el2_dec_ib_fifo.sv
// Bench for el2_dec_ib_fifo: two instances (DEPTH=4/no bypass, DEPTH=8/bypass) on shared
// stimulus, each checked every cycle against a queue-based model, plus literal spot checks.
module tb_el2_dec_ib_fifo;

    typedef struct packed {
        logic [31:0] instr;
        logic [30:0] pc;
        logic        pc4;
        logic        icaf;
        logic        icaf2;
        logic        dbecc;
        logic [1:0]  ictype;
        logic [63:0] sb;
    } ent_t;

    typedef struct {
        bit   ready, dready, valid, dvalid, wrs1, fence;
        bit   enq, byp, deq, dacc;
        ent_t e;
        int   count;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_pc4, in_icaf, in_icaf2, in_dbecc, decode, flush;
    logic [31:0] in_instr;
    logic [30:0] in_pc;
    logic [1:0]  in_ictype;
    logic [63:0] in_sb;
    logic        dv, dw;
    logic [1:0]  dt;
    logic [31:0] da;

    logic a_ready, a_dready, a_valid, a_dvalid, a_pc4, a_icaf, a_icaf2, a_dbecc, a_wrs1, a_fence;
    logic [31:0] a_instr;
    logic [30:0] a_pc;
    logic [1:0]  a_ictype;
    logic [63:0] a_sb;
    logic [2:0]  a_count;
    logic b_ready, b_dready, b_valid, b_dvalid, b_pc4, b_icaf, b_icaf2, b_dbecc, b_wrs1, b_fence;
    logic [31:0] b_instr;
    logic [30:0] b_pc;
    logic [1:0]  b_ictype;
    logic [63:0] b_sb;
    logic [3:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    el2_dec_ib_fifo #(.DEPTH(4), .SB_WIDTH(64), .BYPASS(0)) u_a (
        .clk(clk), .rst(rst),
        .ifu_i0_valid(in_valid), .ifu_ib_ready(a_ready), .ifu_i0_instr(in_instr),
        .ifu_i0_pc(in_pc), .ifu_i0_pc4(in_pc4), .ifu_i0_icaf(in_icaf),
        .ifu_i0_icaf_second(in_icaf2), .ifu_i0_dbecc(in_dbecc), .ifu_i0_icaf_type(in_ictype),
        .ifu_i0_sb(in_sb), .dec_i0_decode_d(decode), .exu_flush_final(flush),
        .dbg_cmd_valid(dv), .dbg_cmd_write(dw), .dbg_cmd_type(dt), .dbg_cmd_addr(da),
        .dbg_cmd_ready(a_dready), .dec_ib0_valid_d(a_valid), .dec_debug_valid_d(a_dvalid),
        .dec_i0_instr_d(a_instr), .dec_i0_pc_d(a_pc), .dec_i0_pc4_d(a_pc4),
        .dec_i0_icaf_d(a_icaf), .dec_i0_icaf_second_d(a_icaf2), .dec_i0_dbecc_d(a_dbecc),
        .dec_i0_icaf_type_d(a_ictype), .dec_i0_sb_d(a_sb),
        .dec_debug_wdata_rs1_d(a_wrs1), .dec_debug_fence_d(a_fence), .dec_ib_count(a_count)
    );

    el2_dec_ib_fifo #(.DEPTH(8), .SB_WIDTH(64), .BYPASS(1)) u_b (
        .clk(clk), .rst(rst),
        .ifu_i0_valid(in_valid), .ifu_ib_ready(b_ready), .ifu_i0_instr(in_instr),
        .ifu_i0_pc(in_pc), .ifu_i0_pc4(in_pc4), .ifu_i0_icaf(in_icaf),
        .ifu_i0_icaf_second(in_icaf2), .ifu_i0_dbecc(in_dbecc), .ifu_i0_icaf_type(in_ictype),
        .ifu_i0_sb(in_sb), .dec_i0_decode_d(decode), .exu_flush_final(flush),
        .dbg_cmd_valid(dv), .dbg_cmd_write(dw), .dbg_cmd_type(dt), .dbg_cmd_addr(da),
        .dbg_cmd_ready(b_dready), .dec_ib0_valid_d(b_valid), .dec_debug_valid_d(b_dvalid),
        .dec_i0_instr_d(b_instr), .dec_i0_pc_d(b_pc), .dec_i0_pc4_d(b_pc4),
        .dec_i0_icaf_d(b_icaf), .dec_i0_icaf_second_d(b_icaf2), .dec_i0_dbecc_d(b_dbecc),
        .dec_i0_icaf_type_d(b_ictype), .dec_i0_sb_d(b_sb),
        .dec_debug_wdata_rs1_d(b_wrs1), .dec_debug_fence_d(b_fence), .dec_ib_count(b_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t    q0[$];
    ent_t    q1[$];
    bit      dp[2];
    bit      dwr[2];
    bit      dfn[2];
    logic [31:0] dins[2];
    bit      model_live = 0;
    int      depth_of[2] = '{4, 8};
    bit      bypass_of[2] = '{1'b0, 1'b1};

    function automatic logic [31:0] dbg_instr_of(input logic [1:0] t, input logic w,
                                                 input logic [31:0] a);
        logic [31:0] rn;
        logic [31:0] csr;
        rn  = {27'b0, a[4:0]};
        csr = {20'b0, a[11:0]};
        if (t == 2'd1) return (w ? 32'h0000_1073 : 32'h0000_2073) | (csr << 20);
        return w ? (32'h0000_6033 | (rn << 7)) : (32'h0000_6033 | (rn << 15));
    endfunction

    function automatic ent_t in_ent();
        return '{in_instr, in_pc, in_pc4, in_icaf, in_icaf2, in_dbecc, in_ictype, in_sb};
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t x;
        int   n;
        n = (i == 0) ? q0.size() : q1.size();
        x = '{default: 0};
        x.count  = n;
        x.dacc   = dv && dt != 2'd2 && !dp[i] && n == 0;
        x.ready  = n != depth_of[i] && !dp[i] && !x.dacc && !flush;
        x.dready = x.dacc;
        x.enq    = in_valid && x.ready;
        x.byp    = bypass_of[i] && n == 0 && x.enq;
        x.deq    = decode && n != 0 && !dp[i];
        x.valid  = dp[i] || n != 0 || x.byp;
        x.dvalid = dp[i];
        x.wrs1   = dp[i] && dwr[i];
        x.fence  = dp[i] && dfn[i];
        if (dp[i])        x.e.instr = dins[i];
        else if (n != 0)  x.e = (i == 0) ? q0[0] : q1[0];
        else if (x.byp)   x.e = in_ent();
        return x;
    endfunction

    task automatic model_step(input int i);
        exp_t x;
        x = model_out(i);
        if (rst) begin
            if (i == 0) q0.delete(); else q1.delete();
            dp[i] = 0;
            return;
        end
        if (flush) begin
            if (i == 0) q0.delete(); else q1.delete();
        end else begin
            if (x.deq) begin
                if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (x.enq && !(x.byp && decode)) begin
                if (i == 0) q0.push_back(in_ent()); else q1.push_back(in_ent());
            end
        end
        if (x.dacc) begin
            dp[i]   = 1;
            dins[i] = dbg_instr_of(dt, dw, da);
            dwr[i]  = dw;
            dfn[i]  = dt == 2'd1 && dw && da[11:0] == 12'h7C4;
        end else if (dp[i] && decode) begin
            dp[i] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) model_live = 1;
        model_step(0);
        model_step(1);
    end

    function automatic exp_t dut_out(input int i);
        exp_t y;
        y = '{default: 0};
        if (i == 0) begin
            y.ready = a_ready; y.dready = a_dready; y.valid = a_valid; y.dvalid = a_dvalid;
            y.wrs1 = a_wrs1; y.fence = a_fence; y.count = int'(a_count);
            y.e = '{a_instr, a_pc, a_pc4, a_icaf, a_icaf2, a_dbecc, a_ictype, a_sb};
        end else begin
            y.ready = b_ready; y.dready = b_dready; y.valid = b_valid; y.dvalid = b_dvalid;
            y.wrs1 = b_wrs1; y.fence = b_fence; y.count = int'(b_count);
            y.e = '{b_instr, b_pc, b_pc4, b_icaf, b_icaf2, b_dbecc, b_ictype, b_sb};
        end
        return y;
    endfunction

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                exp_t x;
                exp_t y;
                string p;
                x = model_out(i);
                y = dut_out(i);
                p = (i == 0) ? "A" : "B";
                check({p, ".ready"},      64'(y.ready),     64'(x.ready));
                check({p, ".dbg_ready"},  64'(y.dready),    64'(x.dready));
                check({p, ".valid"},      64'(y.valid),     64'(x.valid));
                check({p, ".dbg_valid"},  64'(y.dvalid),    64'(x.dvalid));
                check({p, ".instr"},      64'(y.e.instr),   64'(x.e.instr));
                check({p, ".pc"},         64'(y.e.pc),      64'(x.e.pc));
                check({p, ".flags"},      64'({y.e.pc4, y.e.icaf, y.e.icaf2, y.e.dbecc, y.e.ictype}),
                                          64'({x.e.pc4, x.e.icaf, x.e.icaf2, x.e.dbecc, x.e.ictype}));
                check({p, ".sb"},         y.e.sb,           x.e.sb);
                check({p, ".wdata_rs1"},  64'(y.wrs1),      64'(x.wrs1));
                check({p, ".fence"},      64'(y.fence),     64'(x.fence));
                check({p, ".count"},      64'(y.count),     64'(x.count));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        in_valid = 0; in_instr = '0; in_pc = '0; in_pc4 = 0; in_icaf = 0; in_icaf2 = 0;
        in_dbecc = 0; in_ictype = '0; in_sb = '0; decode = 0; flush = 0;
        dv = 0; dw = 0; dt = '0; da = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [30:0] pc);
        in_valid = 1; in_instr = ins; in_pc = pc; in_sb = {ins, 1'b0, pc};
        in_pc4 = ins[0]; in_icaf = ins[1]; in_ictype = ins[3:2];
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (3) adv();
        rst = 0;
        @(negedge clk);
        check("reset.A.ready", 64'(a_ready), 64'(1));
        check("reset.A.valid", 64'(a_valid), 64'(0));
        check("reset.A.instr", 64'(a_instr), 64'(0));
        check("reset.B.count", 64'(b_count), 64'(0));
        check("reset.B.dbg_valid", 64'(b_dvalid), 64'(0));
        adv();

        // Fill the 4-deep registered instance with decode held low.
        for (int k = 0; k < 5; k++) begin
            fetch(32'h1000_0000 + 32'(k), 31'h100 + 31'(k));
            @(negedge clk);
            check($sformatf("fill.A.ready%0d", k), 64'(a_ready), 64'(k < 4));
            if (k == 0) check("fill.A.no_bypass", 64'(a_valid), 64'(0));
            if (k == 1) check("fill.A.head_pc", 64'(a_pc), 64'(31'h100));
            adv();
        end
        idle();
        @(negedge clk);
        check("fill.A.count", 64'(a_count), 64'(4));
        check("fill.A.head_pc_held", 64'(a_pc), 64'(31'h100));
        check("fill.B.count", 64'(b_count), 64'(5));
        adv();
        decode = 1;
        repeat (8) adv();
        idle();

        // Same-cycle bypass on the empty bypass instance.
        fetch(32'h0000_0013, 31'h200);
        decode = 1;
        @(negedge clk);
        check("byp.B.instr", 64'(b_instr), 64'h13);
        check("byp.B.valid", 64'(b_valid), 64'(1));
        adv();
        idle();
        @(negedge clk);
        check("byp.B.count", 64'(b_count), 64'(0));
        check("byp.A.count", 64'(a_count), 64'(1));
        decode = 1;
        adv();
        idle();

        // Flush with concurrent decode and fetch.
        for (int k = 0; k < 3; k++) begin
            fetch(32'h3000_0000 + 32'(k), 31'h300 + 31'(k));
            adv();
        end
        idle();
        @(negedge clk);
        check("flush.A.count_before", 64'(a_count), 64'(3));
        flush = 1; decode = 1; fetch(32'h3333_3333, 31'h3FF);
        @(negedge clk);
        check("flush.A.ready", 64'(a_ready), 64'(0));
        adv();
        idle();
        @(negedge clk);
        check("flush.A.count", 64'(a_count), 64'(0));
        check("flush.A.valid", 64'(a_valid), 64'(0));
        check("flush.B.count", 64'(b_count), 64'(0));
        adv();

        // Debug GPR read of x5 preempts a concurrent fetch.
        dv = 1; dt = 2'd0; dw = 0; da = 32'd5;
        fetch(32'h4000_0000, 31'h400);
        @(negedge clk);
        check("dbg.A.cmd_ready", 64'(a_dready), 64'(1));
        check("dbg.A.fetch_ready", 64'(a_ready), 64'(0));
        adv();
        dv = 0; da = '0;
        @(negedge clk);
        check("dbg.A.instr", 64'(a_instr), 64'h0002_E033);
        check("dbg.A.dbg_valid", 64'(a_dvalid), 64'(1));
        check("dbg.A.pc_zero", 64'(a_pc), 64'(0));
        check("dbg.A.ready_stall", 64'(a_ready), 64'(0));
        adv();
        in_valid = 0;
        decode = 1;
        @(negedge clk);
        check("dbg.B.instr_held", 64'(b_instr), 64'h0002_E033);
        adv();
        idle();
        @(negedge clk);
        check("dbg.A.cleared", 64'(a_dvalid), 64'(0));
        check("dbg.A.ready_back", 64'(a_ready), 64'(1));
        adv();

        // Debug CSR write to 0x7C4.
        dv = 1; dt = 2'd1; dw = 1; da = 32'h0000_07C4;
        adv();
        idle();
        @(negedge clk);
        check("csr.B.instr", 64'(b_instr), 64'h7C40_1073);
        check("csr.B.wdata_rs1", 64'(b_wrs1), 64'(1));
        check("csr.B.fence", 64'(b_fence), 64'(1));
        decode = 1;
        adv();
        idle();

        // Memory-type commands are never accepted.
        dv = 1; dt = 2'd2; dw = 1; da = 32'h0000_1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mem.A.cmd_ready", 64'(a_dready), 64'(0));
            check("mem.B.cmd_ready", 64'(b_dready), 64'(0));
            check("mem.A.fetch_ready", 64'(a_ready), 64'(1));
            adv();
        end
        idle();
        @(negedge clk);
        check("mem.A.dbg_valid", 64'(a_dvalid), 64'(0));
        adv();

        // Random traffic with a mid-run reset; the model checks every cycle.
        for (int c = 0; c < 10000; c++) begin
            bit busy_phase;
            busy_phase = (c % 2000) < 1000;
            rst = (c == 5000);
            if ($urandom_range(0, 9) < 7) fetch($urandom, 31'($urandom));
            else in_valid = 0;
            in_icaf2  = 1'($urandom);
            in_dbecc  = 1'($urandom);
            in_sb     = {$urandom, $urandom};
            decode    = busy_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            dv        = ($urandom_range(0, 39) == 0);
            dt        = 2'($urandom_range(0, 2));
            dw        = 1'($urandom);
            da        = $urandom;
            adv();
        end
        rst = 0;
        idle();
        repeat (4) adv();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/el2_dec_ib_fifo.md
# el2_dec_ib_fifo

Parametrised decode instruction buffer between the aligner and decode. It stores up to DEPTH fetched instructions with their PC, fault and branch-prediction sideband, and can optionally bypass an empty buffer in the same cycle. It also latches abstract debug GPR/CSR commands into a one-entry debug slot that preempts fetch traffic. Decode sees one head instruction per cycle and consumes it with an explicit decode strobe.

## Interface
Parameters:
- DEPTH, 4, buffer entries; power of two, >= 2
- SB_WIDTH, 64, opaque sideband width (packed branch packet, BP index, FGHR, btag, FA index), carried unmodified
- BYPASS, 1, 1 = empty-buffer combinational pass-through; 0 = always registered

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- ifu_i0_valid  in  1  aligner instruction valid
- ifu_ib_ready  out  1  buffer accepts the aligner instruction this cycle
- ifu_i0_instr  in  32  instruction
- ifu_i0_pc  in  31 [31:1]  PC
- ifu_i0_pc4 / ifu_i0_icaf / ifu_i0_icaf_second / ifu_i0_dbecc  in  1 each  4B flag, access fault, fault on second half, double-bit ECC
- ifu_i0_icaf_type  in  2  access fault type
- ifu_i0_sb  in  SB_WIDTH  sideband
- dec_i0_decode_d  in  1  decode consumes the head this cycle
- exu_flush_final  in  1  pipeline flush
- dbg_cmd_valid / dbg_cmd_write  in  1 each  debug command valid, write
- dbg_cmd_type  in  2  0 = GPR, 1 = CSR, 2 = memory (ignored here)
- dbg_cmd_addr  in  32  register/CSR address
- dbg_cmd_ready  out  1  debug command accepted this cycle
- dec_ib0_valid_d  out  1  head valid (fetch or debug)
- dec_debug_valid_d  out  1  head is a debug instruction
- dec_i0_instr_d  out  32; dec_i0_pc_d  out  31; dec_i0_pc4_d, dec_i0_icaf_d, dec_i0_icaf_second_d, dec_i0_dbecc_d  out  1; dec_i0_icaf_type_d  out  2; dec_i0_sb_d  out  SB_WIDTH  head fields
- dec_debug_wdata_rs1_d  out  1  debug write; rs1 sources debug data
- dec_debug_fence_d  out  1  debug CSR write to 0x7C4
- dec_ib_count  out  $clog2(DEPTH)+1  stored fetch entries

## Operation
- State: circular storage[DEPTH], wr_ptr, rd_ptr, count, dbg_pending, dbg_instr[31:0], dbg_wr, dbg_fence. Storage is not reset.
- dbg_acc = dbg_cmd_valid & type != 2 & ~dbg_pending & count == 0; dbg_cmd_ready = dbg_acc. Type 2 is never accepted.
- ifu_ib_ready = (count != DEPTH) & ~dbg_pending & ~dbg_acc & ~exu_flush_final.
- enq = ifu_i0_valid & ifu_ib_ready.
- byp = BYPASS & count == 0 & enq.
- Head valid: dec_ib0_valid_d = dbg_pending | count != 0 | byp. dec_debug_valid_d = dbg_pending.
- Head mux priority: debug slot, then storage[rd_ptr], then bypass inputs. All head data outputs are 0 when dec_ib0_valid_d = 0. A debug head drives pc, fault and sideband outputs to 0.
- Fetch dequeue: deq = dec_i0_decode_d & count != 0 & ~dbg_pending. Advances rd_ptr.
- A bypassed instruction decoded in the same cycle is not written. Otherwise enq writes storage[wr_ptr].
- Count update: count += enq & ~(byp & decode); count -= deq. Pointers wrap modulo DEPTH.
- Debug load on dbg_acc, registered (dbg_pending = 1 next cycle); reg = addr[4:0], csr = addr[11:0]:
  - GPR read: 0x00006033 | reg<<15
  - GPR write: 0x00006033 | reg<<7
  - CSR read: 0x00002073 | csr<<20
  - CSR write: 0x00001073 | csr<<20
  - dbg_wr = write; dbg_fence = CSR write & csr == 0x7C4
- dec_debug_wdata_rs1_d = dbg_pending & dbg_wr; dec_debug_fence_d = dbg_pending & dbg_fence.
- dbg_pending clears on dec_i0_decode_d.
- Flush: count, rd_ptr and wr_ptr go to 0 next cycle; a same-cycle enq is blocked. The debug slot is unaffected.
- Simultaneous decode and flush: flush dominates.
- Simultaneous debug accept and fetch valid: debug wins, fetch is stalled.

## Timing
- Reset: count = 0, pointers = 0, dbg_pending = 0. All outputs are 0 except ifu_ib_ready, which is 1 once rst deasserts.
- Enqueue to head: 0 cycles when BYPASS = 1 and the buffer is empty, else 1 cycle.
- Full throughput: one enqueue and one dequeue per cycle. ready does not credit a same-cycle dequeue (no decode-to-ready path).
- Debug: accept in cycle N, head in N+1, held until decode.
- Reset asserted mid-operation discards all entries and the debug slot on the next edge.

## Test plan
- DEPTH = 4, BYPASS = 0, decode held low, 5 valid fetches → ready drops after 4; count = 4; head = first PC at the following cycle.
- BYPASS = 1, empty buffer, instr 0x00000013 with decode = 1 → dec_i0_instr_d = 0x13 in the same cycle; count stays 0.
- Fill 3 entries, assert exu_flush_final with decode = 1 and ifu_i0_valid = 1 → count = 0 next cycle; valid = 0; no write.
- Empty buffer, dbg GPR read addr 5 → ready pulse; next cycle instr 0x0002E033, debug_valid = 1; fetch ready = 0 until decode.
- dbg CSR write addr 0x7C4 → instr 0x7C401073, wdata_rs1 = 1, fence = 1. dbg type 2 → never accepted.
- Random enqueue/decode for 10k cycles at DEPTH = 8 → wrap-around order preserved; count matches the scoreboard.
